kb_event_sequencer: RTL and testbench

//  Sits between the PS/2 receiver (scan_data/scan_done_tick) and consumers.

---
 rtl/kb_event_sequencer_if.sv | 21 ++
 rtl/kb_event_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_kb_event_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/kb_event_sequencer_if.sv
// Event-path bundle between the PS/2 byte source, the sequencer and its consumer.
interface kb_event_sequencer_if;
   logic       scan_done_tick;
   logic [7:0] scan_data;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_make;
   logic       ev_ext;
   logic       ev_upper;

   modport slave (
      input  scan_done_tick, scan_data, ev_ready,
      output ev_valid, ev_code, ev_make, ev_ext, ev_upper
   );

   modport master (
      output scan_done_tick, scan_data, ev_ready,
      input  ev_valid, ev_code, ev_make, ev_ext, ev_upper
   );
endinterface

// File: rtl/kb_event_sequencer.sv
// Keyboard event sequencer: folds PS/2 scan bytes into whole key events,
// tracks shift/caps modifiers and queues events behind a valid/ready port.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  S_IDLE    | waiting for the first byte of a sequence
//  S_EXT     | E0 seen, next byte is an extended code or F0
//  S_BRK     | F0 seen, next byte is the released code
//  S_EXT_BRK | E0 F0 seen, next byte is a released extended code
//  S_SKIP    | inside a pause sequence, discarding bytes
module kb_event_sequencer #(
   parameter int FIFO_DEPTH = 8,
   parameter int PAUSE_SKIP = 7
) (
   input  logic                  clk,
   input  logic                  reset_n,
   kb_event_sequencer_if.slave   bus,
   output logic                  caps_on,
   output logic                  overflow,
   input  logic                  clr_ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int SW = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);

   localparam logic [7:0] C_EXT   = 8'hE0;
   localparam logic [7:0] C_BRK   = 8'hF0;
   localparam logic [7:0] C_PAUSE = 8'hE1;
   localparam logic [7:0] C_LSHFT = 8'h12;
   localparam logic [7:0] C_RSHFT = 8'h59;
   localparam logic [7:0] C_CAPS  = 8'h58;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK,
      S_SKIP
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [SW-1:0]   r_skip_cnt;
   logic [SW-1:0]   w_skip_next;
   logic            w_cmpl;
   logic            w_make;
   logic            w_ext;

   logic            r_shift_l;
   logic            r_shift_r;
   logic            r_caps_on;
   logic            r_caps_held;
   logic            r_overflow;

   logic            w_is_shl;
   logic            w_is_shr;
   logic            w_is_caps;
   logic            w_is_fake;
   logic            w_push;
   logic            w_upper;

   logic [10:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_wr_en;
   logic            w_drop;
   logic [10:0]     w_head;

   // Parser state and pause skip down-counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_skip_cnt <= '0;
      end else begin
         r_state    <= w_next_state;
         r_skip_cnt <= w_skip_next;
      end
   end

   // Next-state decode; flags a completed code with its make/ext attributes.
   always_comb begin
      w_next_state = r_state;
      w_skip_next  = r_skip_cnt;
      w_cmpl       = 1'b0;
      w_make       = 1'b0;
      w_ext        = 1'b0;
      if (bus.scan_done_tick) begin
         case (r_state)
            S_IDLE: begin
               if (bus.scan_data == C_EXT) begin
                  w_next_state = S_EXT;
               end else if (bus.scan_data == C_BRK) begin
                  w_next_state = S_BRK;
               end else if (bus.scan_data == C_PAUSE) begin
                  w_next_state = S_SKIP;
                  w_skip_next  = SW'(PAUSE_SKIP);
               end else begin
                  w_cmpl = 1'b1;
                  w_make = 1'b1;
               end
            end
            S_EXT: begin
               if (bus.scan_data == C_BRK) begin
                  w_next_state = S_EXT_BRK;
               end else begin
                  w_cmpl       = 1'b1;
                  w_make       = 1'b1;
                  w_ext        = 1'b1;
                  w_next_state = S_IDLE;
               end
            end
            S_BRK: begin
               w_cmpl       = 1'b1;
               w_next_state = S_IDLE;
            end
            S_EXT_BRK: begin
               w_cmpl       = 1'b1;
               w_ext        = 1'b1;
               w_next_state = S_IDLE;
            end
            S_SKIP: begin
               w_skip_next = (r_skip_cnt == '0) ? '0 : r_skip_cnt - SW'(1);
               if (r_skip_cnt <= SW'(1)) begin
                  w_next_state = S_IDLE;
               end
            end
            default: begin
               w_next_state = S_IDLE;
            end
         endcase
      end
   end

   // Modifier keys are absorbed here; everything else becomes a queued event.
   assign w_is_shl  = w_cmpl && !w_ext && (bus.scan_data == C_LSHFT);
   assign w_is_shr  = w_cmpl && !w_ext && (bus.scan_data == C_RSHFT);
   assign w_is_caps = w_cmpl && !w_ext && (bus.scan_data == C_CAPS);
   assign w_is_fake = w_cmpl &&  w_ext && (bus.scan_data == C_LSHFT);
   assign w_push    = w_cmpl && !(w_is_shl || w_is_shr || w_is_caps || w_is_fake);
   assign w_upper   = (r_shift_l | r_shift_r) ^ r_caps_on;

   // Shift levels and caps toggle; caps_held suppresses typematic re-toggling.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift_l   <= 1'b0;
         r_shift_r   <= 1'b0;
         r_caps_on   <= 1'b0;
         r_caps_held <= 1'b0;
      end else begin
         if (w_is_shl) begin
            r_shift_l <= w_make;
         end
         if (w_is_shr) begin
            r_shift_r <= w_make;
         end
         if (w_is_caps) begin
            if (!w_make) begin
               r_caps_held <= 1'b0;
            end else if (!r_caps_held) begin
               r_caps_on   <= ~r_caps_on;
               r_caps_held <= 1'b1;
            end
         end
      end
   end

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_pop   = !w_empty && bus.ev_ready;
   assign w_wr_en = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;

   // Queue pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_wr_en && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_wr_en && w_pop) begin
            r_count <= r_count - CW'(1);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // Event storage; contents are only observed through the valid-gated head.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= {bus.scan_data, w_make, w_ext, w_upper};
      end
   end

   assign w_head       = w_empty ? '0 : r_mem[r_rd_ptr];
   assign bus.ev_valid = !w_empty;
   assign bus.ev_code  = w_head[10:3];
   assign bus.ev_make  = w_head[2];
   assign bus.ev_ext   = w_head[1];
   assign bus.ev_upper = w_head[0];
   assign caps_on      = r_caps_on;
   assign overflow     = r_overflow;

endmodule

// File: tb/tb_kb_event_sequencer.sv
// Bench for kb_event_sequencer: directed byte streams against a queue-based model.
module tb_kb_event_sequencer;
   localparam int DEPTH = 8;
   localparam int SKIP  = 7;

   typedef struct packed {
      logic [7:0] code;
      logic       make;
      logic       ext;
      logic       upper;
   } ev_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clr_ovf = 1'b0;
   logic caps_on;
   logic overflow;

   kb_event_sequencer_if bus();

   kb_event_sequencer #(.FIFO_DEPTH(DEPTH), .PAUSE_SKIP(SKIP)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .caps_on  (caps_on),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   ev_t m_q[$];
   bit  m_ext, m_brk, m_sl, m_sr, m_caps, m_held, m_ovf;
   int  m_skip;
   bit  m_full, m_pop, m_has;
   ev_t m_e;
   ev_t m_head;

   function automatic void m_byte(input logic [7:0] b, output bit has, output ev_t e);
      bit mk, ex, done;
      has = 0; e = '0; done = 0; mk = 1; ex = 0;
      if (m_skip > 0) begin
         m_skip--;
      end else if (!m_ext && !m_brk) begin
         if (b == 8'hE0) m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else if (b == 8'hE1) m_skip = SKIP;
         else done = 1;
      end else if (m_ext && !m_brk) begin
         if (b == 8'hF0) m_brk = 1;
         else begin done = 1; ex = 1; m_ext = 0; end
      end else begin
         done = 1; mk = 0; ex = m_ext; m_ext = 0; m_brk = 0;
      end
      if (done) begin
         if (!ex && b == 8'h12) m_sl = mk;
         else if (!ex && b == 8'h59) m_sr = mk;
         else if (!ex && b == 8'h58) begin
            if (!mk) m_held = 0;
            else if (!m_held) begin m_caps = !m_caps; m_held = 1; end
         end else if (!(ex && b == 8'h12)) begin
            has = 1;
            e.code = b; e.make = mk; e.ext = ex; e.upper = (m_sl | m_sr) ^ m_caps;
         end
      end
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_ext = 0; m_brk = 0; m_sl = 0; m_sr = 0; m_caps = 0; m_held = 0; m_ovf = 0;
         m_skip = 0;
      end else begin
         m_full = (m_q.size() == DEPTH);
         m_pop  = (m_q.size() != 0) && bus.ev_ready;
         m_has  = 0;
         m_e    = '0;
         if (bus.scan_done_tick) m_byte(bus.scan_data, m_has, m_e);
         if (m_pop) m_q.delete(0);
         if (m_has && (!m_full || m_pop)) m_q.push_back(m_e);
         if (m_has && m_full && !m_pop) m_ovf = 1;
         else if (clr_ovf) m_ovf = 0;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (reset_n) begin
         m_head = (m_q.size() != 0) ? m_q[0] : '0;
         chk("model", {18'd0, bus.ev_valid, bus.ev_code, bus.ev_make, bus.ev_ext, bus.ev_upper, caps_on, overflow},
                      {18'd0, (m_q.size() != 0), m_head, m_caps, m_ovf});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input logic [7:0] b);
      @(negedge clk);
      bus.scan_data      = b;
      bus.scan_done_tick = 1'b1;
      @(negedge clk);
      bus.scan_done_tick = 1'b0;
   endtask

   task automatic pop_one();
      @(negedge clk);
      bus.ev_ready = 1'b1;
      @(negedge clk);
      bus.ev_ready = 1'b0;
   endtask

   task automatic expect_head(input string name, input logic [7:0] code, input logic mk, input logic ex, input logic up);
      chk(name, {20'd0, bus.ev_valid, bus.ev_code, bus.ev_make, bus.ev_ext, bus.ev_upper},
                {20'd0, 1'b1, code, mk, ex, up});
   endtask

   logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

   initial begin
      bus.scan_done_tick = 1'b0;
      bus.scan_data      = 8'h00;
      bus.ev_ready       = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", {19'd0, bus.ev_valid, bus.ev_code, bus.ev_make, bus.ev_ext, bus.ev_upper, caps_on, overflow}, 32'd0);
      reset_n = 1'b1;

      // 1: make/break with ready held high
      bus.ev_ready = 1'b1;
      tick(8'h1C);
      expect_head("t1_make", 8'h1C, 1, 0, 0);
      tick(8'hF0);
      tick(8'h1C);
      expect_head("t1_break", 8'h1C, 0, 0, 0);
      @(negedge clk);
      bus.ev_ready = 1'b0;
      chk("t1_drained", {31'd0, bus.ev_valid}, 32'd0);

      // 2: shift affects case, shift bytes produce no event
      tick(8'h12); tick(8'h1C); tick(8'hF0); tick(8'h12); tick(8'h1C);
      expect_head("t2_shifted", 8'h1C, 1, 0, 1);
      pop_one();
      expect_head("t2_plain", 8'h1C, 1, 0, 0);
      pop_one();
      chk("t2_empty", {31'd0, bus.ev_valid}, 32'd0);

      // 3: caps toggle with typematic repeat, then shift+caps
      tick(8'h58);
      chk("t3_caps_first", {31'd0, caps_on}, 32'd1);
      tick(8'h58);
      chk("t3_caps_repeat", {31'd0, caps_on}, 32'd1);
      tick(8'hF0); tick(8'h58);
      tick(8'h1C);
      expect_head("t3_caps_upper", 8'h1C, 1, 0, 1);
      pop_one();
      tick(8'h59); tick(8'h1C);
      expect_head("t3_shift_caps", 8'h1C, 1, 0, 0);
      pop_one();
      tick(8'hF0); tick(8'h59);
      tick(8'h58);
      chk("t3_caps_off", {31'd0, caps_on}, 32'd0);
      tick(8'hF0); tick(8'h58);

      // 4: extended make/break, print-screen fake shift, pause sequence
      tick(8'hE0); tick(8'h75);
      expect_head("t4_ext_make", 8'h75, 1, 1, 0);
      pop_one();
      tick(8'hE0); tick(8'hF0); tick(8'h75);
      expect_head("t4_ext_break", 8'h75, 0, 1, 0);
      pop_one();
      tick(8'hE0); tick(8'h12);
      chk("t4_fake_shift", {31'd0, bus.ev_valid}, 32'd0);
      for (int i = 0; i < 8; i++) tick(pause_seq[i]);
      chk("t4_pause_silent", {31'd0, bus.ev_valid}, 32'd0);
      tick(8'h1C);
      expect_head("t4_after_pause", 8'h1C, 1, 0, 0);
      pop_one();

      // 5: overflow with ready low, ordered drain, clear
      for (int i = 0; i <= DEPTH; i++) tick(8'h15 + 8'(i));
      chk("t5_overflow", {31'd0, overflow}, 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         expect_head($sformatf("t5_drain%0d", i), 8'h15 + 8'(i), 1, 0, 0);
         pop_one();
      end
      chk("t5_empty", {31'd0, bus.ev_valid}, 32'd0);
      chk("t5_ovf_sticky", {31'd0, overflow}, 32'd1);
      @(negedge clk); clr_ovf = 1'b1;
      @(negedge clk); clr_ovf = 1'b0;
      chk("t5_ovf_cleared", {31'd0, overflow}, 32'd0);

      // 6: full queue with simultaneous pop and push
      for (int i = 0; i < DEPTH; i++) tick(8'h21 + 8'(i));
      @(negedge clk);
      bus.scan_data      = 8'h29;
      bus.scan_done_tick = 1'b1;
      bus.ev_ready       = 1'b1;
      @(negedge clk);
      bus.scan_done_tick = 1'b0;
      bus.ev_ready       = 1'b0;
      chk("t6_no_ovf", {31'd0, overflow}, 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         expect_head($sformatf("t6_drain%0d", i), 8'h22 + 8'(i), 1, 0, 0);
         pop_one();
      end
      chk("t6_empty", {31'd0, bus.ev_valid}, 32'd0);

      // 6b: asynchronous reset while in EXT with caps on and an event queued
      tick(8'h58); tick(8'hF0); tick(8'h58);
      tick(8'h1C); tick(8'hE0);
      chk("t6_pre_reset", {30'd0, bus.ev_valid, caps_on}, 32'd3);
      #2 reset_n = 1'b0;
      #1 chk("t6_async_reset", {30'd0, bus.ev_valid, caps_on}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick(8'h1C);
      expect_head("t6_post_reset", 8'h1C, 1, 0, 0);
      pop_one();

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
